// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared types and default parameters for the gate_not sequencer.
//   seq_state_t     - sequencer FSM state encoding
//   TEST_NUMBER_DEF - default number of vectors per run
//   DELAY_DEF       - default settle cycles per vector
package gate_seq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StCheck  = 2'd2,
        StDone   = 2'd3
    } seq_state_t;

    localparam int unsigned TEST_NUMBER_DEF = 5;
    localparam int unsigned DELAY_DEF       = 1;

endpackage

// File: rtl/gate_seq_if.sv
// gate_seq_if: bundles the sequencer's start/status register side and the
// gate stimulus/response side into one port.
//   master - sequencer view: start and gate responses in; stimulus and status out
//   slave  - environment view: drives start and the gate responses
interface gate_seq_if
    import gate_seq_pkg::*;
#(
    parameter int unsigned CNT_W = $clog2(TEST_NUMBER_DEF + 1)
) ();

    logic             start;
    logic             resp_logic;
    logic             resp_instance;
    logic             stim;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_idx;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_fail;

    modport master (
        input  start, resp_logic, resp_instance,
        output stim, busy, done, pass, vec_idx, err_count, first_fail
    );

    modport slave (
        output start, resp_logic, resp_instance,
        input  stim, busy, done, pass, vec_idx, err_count, first_fail
    );

endinterface

// File: rtl/delay_timer.sv
// delay_timer: loadable down-counter that times the per-vector settle window.
//   clk, rst - clock and asynchronous active-high reset
//   load_i   - load DELAY-1 (takes priority over dec_i)
//   dec_i    - decrement by one; holds at zero
//   zero_o   - counter is zero
module delay_timer #(
    parameter int unsigned DELAY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    // Counter only has to hold DELAY-1; keep at least one bit for DELAY=1.
    localparam int unsigned W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [W-1:0] LoadVal = W'(DELAY - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: clocked self-checking sequencer for the gate_not inverter.
// Drives a toggling stimulus starting at 0, waits DELAY settle cycles per
// vector, then checks both gate outputs against ~stim.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - gate_seq_if.master: start, resp_logic, resp_instance in;
//              stim, busy, done, pass, vec_idx, err_count, first_fail out
module gate_seq_ctrl
    import gate_seq_pkg::*;
#(
    parameter int unsigned TEST_NUMBER = TEST_NUMBER_DEF,
    parameter int unsigned DELAY       = DELAY_DEF,
    parameter int unsigned CNT_W       = $clog2(TEST_NUMBER + 1)
) (
    input  logic       clk,
    input  logic       rst,
    gate_seq_if.master bus
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(TEST_NUMBER - 1);

    seq_state_t       state_q, state_d;
    logic             stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic             expected, mismatch;
    logic [CNT_W-1:0] err_inc;

    delay_timer #(
        .DELAY (DELAY)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    always_comb begin
        expected = ~stim_q;
        mismatch = (bus.resp_logic != expected) || (bus.resp_instance != expected);
        // Saturate rather than wrap so a long failing run never reads as clean.
        err_inc  = (mismatch && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
    end

    always_comb begin
        state_d   = state_q;
        stim_d    = stim_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        vec_idx_d = vec_idx_q;
        err_d     = err_q;
        first_d   = first_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d   = StSettle;
                    stim_d    = 1'b0;
                    vec_idx_d = '0;
                    err_d     = '0;
                    first_d   = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    tmr_load  = 1'b1;
                end
            end
            StSettle: begin
                if (tmr_zero) begin
                    state_d = StCheck;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            StCheck: begin
                err_d = err_inc;
                if (mismatch && (err_q == '0)) begin
                    first_d = vec_idx_q;
                end
                if (vec_idx_q == LastIdx) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_inc == '0);
                end else begin
                    state_d   = StSettle;
                    vec_idx_d = vec_idx_q + CNT_W'(1);
                    stim_d    = ~stim_q;
                    tmr_load  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            stim_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            vec_idx_q <= '0;
            err_q     <= '0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            vec_idx_q <= vec_idx_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    assign bus.stim       = stim_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.vec_idx    = vec_idx_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = first_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// tb_gate_seq_ctrl: directed bench for gate_seq_ctrl.
//   dut_a - defaults, correct gate or resp_instance stuck at 0
//   dut_b - TEST_NUMBER=1, DELAY=3, correct gate
//   dut_c - TEST_NUMBER=3, DELAY=1, always-wrong gate
// Cycle numbering: the edge that samples start is cycle 0; "cycle k" is the
// interval after edge k-1, sampled 1 time unit after that edge.
module tb_gate_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic stuck_a;
    int   n_checks = 0;
    int   n_pass   = 0;

    gate_seq_if #(.CNT_W(3)) bus_a ();
    gate_seq_if #(.CNT_W(1)) bus_b ();
    gate_seq_if #(.CNT_W(2)) bus_c ();

    assign bus_a.resp_logic    = ~bus_a.stim;
    assign bus_a.resp_instance = stuck_a ? 1'b0 : ~bus_a.stim;
    assign bus_b.resp_logic    = ~bus_b.stim;
    assign bus_b.resp_instance = ~bus_b.stim;
    assign bus_c.resp_logic    = bus_c.stim;
    assign bus_c.resp_instance = bus_c.stim;

    gate_seq_ctrl dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    gate_seq_ctrl #(
        .TEST_NUMBER (1),
        .DELAY       (3)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    gate_seq_ctrl #(
        .TEST_NUMBER (3),
        .DELAY       (1)
    ) dut_c (
        .clk (clk),
        .rst (rst_c),
        .bus (bus_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut_a for one edge; returns in cycle 1.
    task automatic kick_a();
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        stuck_a     = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        step();
        step();

        // Reset state
        check_eq("rst_busy", bus_a.busy, 0);
        check_eq("rst_done", bus_a.done, 0);
        check_eq("rst_pass", bus_a.pass, 0);
        check_eq("rst_stim", bus_a.stim, 0);
        check_eq("rst_vec", bus_a.vec_idx, 0);
        check_eq("rst_err", bus_a.err_count, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        step();

        // Correct gate, defaults: stim 0,1,0,1,0 each for 2 cycles, done at 11
        kick_a();
        for (int c = 1; c <= 11; c++) begin
            if (c <= 10) begin
                check_eq("t1_stim", bus_a.stim, ((c - 1) / 2) % 2);
                check_eq("t1_busy", bus_a.busy, 1);
            end
            check_eq("t1_done", bus_a.done, (c == 11) ? 1 : 0);
            if (c < 11) step();
        end
        check_eq("t1_pass", bus_a.pass, 1);
        check_eq("t1_err", bus_a.err_count, 0);
        check_eq("t1_vec", bus_a.vec_idx, 4);
        check_eq("t1_busy_end", bus_a.busy, 0);

        // Stuck resp_instance: vectors 0,2,4 fail
        stuck_a = 1'b1;
        kick_a();
        check_eq("t2_done_drop", bus_a.done, 0);
        step();
        step();
        check_eq("t2_err_v0", bus_a.err_count, 1);
        repeat (8) step();
        check_eq("t2_done", bus_a.done, 1);
        check_eq("t2_err", bus_a.err_count, 3);
        check_eq("t2_first", bus_a.first_fail, 0);
        check_eq("t2_pass", bus_a.pass, 0);

        // Start while busy is ignored
        stuck_a = 1'b0;
        kick_a();
        repeat (3) step();
        check_eq("t4_vec_c4", bus_a.vec_idx, 1);
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        check_eq("t4_vec_c5", bus_a.vec_idx, 2);
        check_eq("t4_busy_c5", bus_a.busy, 1);
        repeat (5) step();
        check_eq("t4_done_c10", bus_a.done, 0);
        step();
        check_eq("t4_done_c11", bus_a.done, 1);
        check_eq("t4_pass", bus_a.pass, 1);

        // Reset mid-run at cycle 6 (err already 1 from vector 0)
        stuck_a = 1'b1;
        kick_a();
        repeat (5) step();
        check_eq("t5_pre_vec", bus_a.vec_idx, 2);
        rst_a = 1'b1;
        #1;
        check_eq("t5_busy", bus_a.busy, 0);
        check_eq("t5_vec", bus_a.vec_idx, 0);
        check_eq("t5_err", bus_a.err_count, 0);
        check_eq("t5_done", bus_a.done, 0);
        check_eq("t5_stim", bus_a.stim, 0);
        step();
        rst_a = 1'b0;
        step();
        kick_a();
        check_eq("t5_re_vec", bus_a.vec_idx, 0);
        check_eq("t5_re_busy", bus_a.busy, 1);
        repeat (9) step();
        check_eq("t5_re_done10", bus_a.done, 0);
        step();
        check_eq("t5_re_done11", bus_a.done, 1);
        check_eq("t5_re_err", bus_a.err_count, 3);

        // Parameter corner: TEST_NUMBER=1, DELAY=3
        bus_b.start = 1'b1;
        step();
        bus_b.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_eq("t3_stim", bus_b.stim, 0);
            check_eq("t3_busy", bus_b.busy, 1);
            check_eq("t3_done_lo", bus_b.done, 0);
            step();
        end
        check_eq("t3_done", bus_b.done, 1);
        check_eq("t3_pass", bus_b.pass, 1);
        check_eq("t3_busy_end", bus_b.busy, 0);

        // Saturation corner: CNT_W=2, every vector wrong
        bus_c.start = 1'b1;
        step();
        bus_c.start = 1'b0;
        repeat (5) step();
        check_eq("t6_done_c6", bus_c.done, 0);
        step();
        check_eq("t6_done_c7", bus_c.done, 1);
        check_eq("t6_err", bus_c.err_count, 3);
        check_eq("t6_pass", bus_c.pass, 0);
        check_eq("t6_first", bus_c.first_fail, 0);
        bus_c.start = 1'b1;
        step();
        bus_c.start = 1'b0;
        check_eq("t6_restart_err", bus_c.err_count, 0);
        check_eq("t6_restart_done", bus_c.done, 0);
        check_eq("t6_restart_busy", bus_c.busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Self-checking sequencer for the single-input inverter block (`gate_not`). It drives the gate's `signal` input through a toggling vector sequence that starts at 0. It waits a programmable settle time per vector, then compares both gate outputs (`not_logic`, `not_instance`) against the expected inverse. It reports busy/done status, a mismatch count, the first failing vector index, and a pass flag. It sits between a start/status register interface and the gate instance, replacing the free-running stimulus loop with a clocked, synthesizable controller.

## Interface
- `TEST_NUMBER`, default 5: number of vectors per run; must be ≥ 1.
- `DELAY`, default 1: settle cycles per vector before the check; must be ≥ 1.
- `CNT_W`, default `$clog2(TEST_NUMBER+1)`: width of the index and count outputs.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: run request, sampled only in IDLE or DONE.
- `resp_logic`  in  1: gate output `not_logic`.
- `resp_instance`  in  1: gate output `not_instance`.
- `stim`  out  1: drives gate input `signal`.
- `busy`  out  1: high while a run is in progress (SETTLE or CHECK).
- `done`  out  1: high in DONE; held until the next start or reset.
- `pass`  out  1: valid when `done`=1; equals (`err_count`==0).
- `vec_idx`  out  CNT_W: current vector index, 0 .. TEST_NUMBER-1.
- `err_count`  out  CNT_W: number of vectors with at least one mismatching output; saturates at all-ones.
- `first_fail`  out  CNT_W: index of the first mismatching vector; meaningful only when `err_count`>0.

## Operation
- **States:** IDLE, SETTLE, CHECK, DONE.
- **Reset values:** all outputs are 0 and the state is IDLE. Assertion of `rst` takes effect immediately, including mid-run.
- **IDLE or DONE with `start`=1:** go to SETTLE. Set `stim`=0, `vec_idx`=0, `err_count`=0, `first_fail`=0, `done`=0, `pass`=0, `busy`=1, and load the settle counter to DELAY-1.
- **SETTLE:** if the counter is 0, go to CHECK; otherwise decrement. `stim` is held stable.
- **CHECK:**
  - Expected value is `~stim`. A mismatch is `resp_logic`≠expected OR `resp_instance`≠expected.
  - On a mismatch, increment `err_count` (saturating). If `err_count` was 0, capture `vec_idx` into `first_fail`.
  - If `vec_idx`==TEST_NUMBER-1, go to DONE with `busy`=0, `done`=1, and `pass`=(updated `err_count`==0).
  - Otherwise increment `vec_idx`, set `stim`=~`stim`, reload the counter to DELAY-1, and go to SETTLE.
- **DONE:** all results hold; `stim` holds its last value.
- **Start while busy:** `start` in SETTLE or CHECK is ignored and has no effect on the run.
- **Level-held start:** if `start` stays high in DONE, a new run begins on the next cycle, with `done` dropping as the run starts.
- **Responses:** the block treats responses as combinational from `stim`. A one-cycle registered gate also passes, provided DELAY ≥ 1.

## Timing
- Cycle 0 is the edge that samples `start`=1. SETTLE occupies cycles 1..DELAY, and the CHECK for vector 0 is at cycle DELAY+1.
- Each vector takes DELAY+1 cycles.
- The last CHECK is at cycle TEST_NUMBER·(DELAY+1), and `done` rises at cycle TEST_NUMBER·(DELAY+1)+1.
- `stim` changes only on the edge that leaves CHECK, so it is stable for the full DELAY+1 cycles of each vector.
- Responses are sampled at the CHECK-cycle edge.
- Output arithmetic is unsigned at CNT_W. The `vec_idx` increment never wraps because of the terminal check.

## Structure
- **Package `gate_seq_pkg`:** state enum typedef `seq_state_t` (IDLE, SETTLE, CHECK, DONE) and default constants `TEST_NUMBER_DEF`=5 and `DELAY_DEF`=1.
- **Sub-module `delay_timer`:** a loadable down-counter with a `zero` flag, parameterized by DELAY.
- **Top level:** the FSM, vector and error bookkeeping, and comparison logic.

## Test plan
- **Correct gate, defaults:** instantiate the correct `gate_not`, pulse `start`. Require the `stim` sequence 0,1,0,1,0 with each value held 2 cycles, `done`=1 at cycle 11, `pass`=1, `err_count`=0.
- **Stuck output:** tie `resp_instance` to 0 with defaults. Require mismatches on vectors 0, 2 and 4, giving `err_count`=3, `first_fail`=0, `pass`=0.
- **Parameter corner:** TEST_NUMBER=1, DELAY=3. Require `stim`=0 through cycles 1–4, CHECK at cycle 4, `done` at cycle 5.
- **Start while busy:** pulse `start` again at cycle 4 of a default run. Require no restart, `vec_idx` continuing 1→2, and `done` still at cycle 11.
- **Reset mid-run:** assert `rst` at cycle 6. Require all outputs 0 immediately. After release, pulse `start` and require a full run from vector 0.
- **Saturation:** TEST_NUMBER=3 (CNT_W=2) with an always-wrong gate. Require `err_count`=3 and no wrap, then a restart from DONE that clears the count to 0.
